// File: rtl/vga_pkg.sv
// Shared raster timing constants and the width helper used by the timing generator.
package vga_pkg;

  function automatic int vga_clog2(input int value);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < value) begin
      p = p * 2;
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // 640x480@60, 25.175 MHz nominal pixel clock, negative syncs
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x600@60, 40 MHz nominal pixel clock, positive syncs
  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FP     = 40;
  localparam int VGA800_H_SYNC   = 128;
  localparam int VGA800_H_BP     = 88;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FP     = 1;
  localparam int VGA800_V_SYNC   = 4;
  localparam int VGA800_V_BP     = 23;

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter with registered active/sync decode.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int TOTAL  = 800,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int W      = vga_clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  output logic [W-1:0] count_o,
  output logic [W-1:0] next_o,
  output logic         active_o,
  output logic         sync_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] count_q, count_d;
  logic         active_q, active_d;
  logic         sync_q, sync_d;
  logic         wrap;

  // cnt_q starts on the last position so the first step lands on 0;
  // count_q is the visible copy, which reads 0 until that first step.
  always_comb begin
    wrap     = step && (cnt_q == LAST);
    cnt_d    = cnt_q;
    count_d  = count_q;
    active_d = active_q;
    sync_d   = sync_q;
    if (step) begin
      cnt_d    = wrap ? '0 : cnt_q + 1'b1;
      count_d  = cnt_d;
      active_d = int'(cnt_d) < ACTIVE;
      sync_d   = (int'(cnt_d) >= ACTIVE + FP) && (int'(cnt_d) < ACTIVE + FP + SYNC);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= LAST;
      count_q  <= '0;
      active_q <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      active_q <= active_d;
      sync_q   <= sync_d;
    end
  end

  assign count_o  = count_q;
  assign next_o   = cnt_d;
  assign active_o = active_q;
  assign sync_o   = sync_q;
  assign wrap_o   = wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: fractional pixel strobe, HS/VS/DE, position, event pulses.
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int              ACC_W    = 16,
  parameter logic [ACC_W-1:0] STRB_INC = 16'h4000,
  parameter int              H_ACTIVE = VGA640_H_ACTIVE,
  parameter int              H_FP     = VGA640_H_FP,
  parameter int              H_SYNC   = VGA640_H_SYNC,
  parameter int              H_BP     = VGA640_H_BP,
  parameter int              V_ACTIVE = VGA640_V_ACTIVE,
  parameter int              V_FP     = VGA640_V_FP,
  parameter int              V_SYNC   = VGA640_V_SYNC,
  parameter int              V_BP     = VGA640_V_BP,
  parameter bit              HS_POL   = 1'b0,
  parameter bit              VS_POL   = 1'b0,
  parameter int              FC_W     = 8,
  localparam int             H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int             V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int             X_W      = vga_clog2(H_TOTAL),
  localparam int             Y_W      = vga_clog2(V_TOTAL)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en_i,
  output logic            pix_strb_o,
  output logic            hs_o,
  output logic            vs_o,
  output logic            de_o,
  output logic [X_W-1:0]  x_o,
  output logic [Y_W-1:0]  y_o,
  output logic            frame_start_o,
  output logic            line_end_o,
`ifdef VGA_FRAME_CNT_EN
  output logic            animate_o,
  output logic [FC_W-1:0] frame_cnt_o
`else
  output logic            animate_o
`endif
);

  localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT  = Y_W'(V_ACTIVE);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;
  logic             strb_q, strb_d;
  logic             fs_q, fs_d;
  logic             le_q, le_d;
  logic             an_q, an_d;

  logic [X_W-1:0] h_count, h_next;
  logic [Y_W-1:0] v_count, v_next;
  logic           h_active, h_sync, h_wrap;
  logic           v_active, v_sync, v_wrap;

  // The carry drives the counters on the same edge that registers it, so
  // position and pulses are already updated in the clk where pix_strb_o is high.
  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, STRB_INC};
    acc_d  = acc_q;
    strb_d = 1'b0;
    if (en_i) begin
      acc_d  = sum[ACC_W-1:0];
      strb_d = sum[ACC_W];
    end
    fs_d = h_wrap && v_wrap;
    le_d = strb_d && (h_next == H_LAST);
    an_d = h_wrap && (v_next == V_ACT);
  end

  vga_axis_cnt #(
    .TOTAL (H_TOTAL),
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .W     (X_W)
  ) u_h_cnt (
    .clk     (clk),
    .reset   (reset),
    .step    (strb_d),
    .count_o (h_count),
    .next_o  (h_next),
    .active_o(h_active),
    .sync_o  (h_sync),
    .wrap_o  (h_wrap)
  );

  vga_axis_cnt #(
    .TOTAL (V_TOTAL),
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .W     (Y_W)
  ) u_v_cnt (
    .clk     (clk),
    .reset   (reset),
    .step    (h_wrap),
    .count_o (v_count),
    .next_o  (v_next),
    .active_o(v_active),
    .sync_o  (v_sync),
    .wrap_o  (v_wrap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      strb_q <= 1'b0;
      fs_q   <= 1'b0;
      le_q   <= 1'b0;
      an_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      strb_q <= strb_d;
      fs_q   <= fs_d;
      le_q   <= le_d;
      an_q   <= an_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [FC_W-1:0] fc_q, fc_d;

  // Starts at all-ones so the first frame_start brings it to 0.
  always_comb begin
    fc_d = fc_q;
    if (fs_d) fc_d = fc_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fc_q <= '1;
    else       fc_q <= fc_d;
  end

  assign frame_cnt_o = fc_q;
`endif

  assign pix_strb_o    = strb_q;
  assign x_o           = h_count;
  assign y_o           = v_count;
  assign de_o          = h_active && v_active;
  assign hs_o          = HS_POL ? h_sync : ~h_sync;
  assign vs_o          = VS_POL ? v_sync : ~v_sync;
  assign frame_start_o = fs_q;
  assign line_end_o    = le_q;
  assign animate_o     = an_q;

endmodule
